// File: rtl/zcmt_table_fetch_pkg.sv
// Shared Zcmt definitions: core configuration view, cache-port structs,
// table-fetch FSM states and the response bundle seen by the decoder.
package zcmt_table_fetch_pkg;

   typedef struct packed {
      int unsigned XLEN;
      int unsigned DCACHE_INDEX_WIDTH;
      int unsigned DCACHE_TAG_WIDTH;
   } zcmt_cfg_t;

   localparam zcmt_cfg_t ZCMT_CFG_DEFAULT = '{XLEN: 32, DCACHE_INDEX_WIDTH: 12, DCACHE_TAG_WIDTH: 20};

   localparam int unsigned ZCMT_IDX_W       = 12;
   localparam int unsigned ZCMT_TAG_W       = 20;
   localparam int unsigned ZCMT_ID_W        = 2;
   localparam int unsigned ZCMT_DATA_W      = 32;
   localparam int unsigned ZCMT_ENTRY_BYTES = 4;

   typedef enum logic [2:0] {
      ZCMT_IDLE,
      ZCMT_REQ,
      ZCMT_TAG,
      ZCMT_KILL,
      ZCMT_WAIT,
      ZCMT_DROP
   } zcmt_fetch_state_e;

   typedef struct packed {
      logic                   valid;
      logic                   err;
      logic [ZCMT_DATA_W-1:0] data;
   } zcmt_fetch_rsp_t;

   // Load-port request (block -> data cache)
   typedef struct packed {
      logic [ZCMT_IDX_W-1:0]  address_index;
      logic [ZCMT_TAG_W-1:0]  address_tag;
      logic [ZCMT_DATA_W-1:0] data_wdata;
      logic                   data_wuser;
      logic                   data_req;
      logic                   data_we;
      logic [3:0]             data_be;
      logic [1:0]             data_size;
      logic [ZCMT_ID_W-1:0]   data_id;
      logic                   kill_req;
      logic                   tag_valid;
   } zcmt_dcache_req_t;

   // Load-port response (data cache -> block)
   typedef struct packed {
      logic                   data_gnt;
      logic                   data_rvalid;
      logic [ZCMT_ID_W-1:0]   data_rid;
      logic [ZCMT_DATA_W-1:0] data_rdata;
   } zcmt_dcache_rsp_t;

endpackage

// File: rtl/zcmt_entry_cache.sv
// One-entry jump-table cache: remembers the last fetched {address, target}.
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   inval_i          clear the valid bit (wins over a same-cycle fill)
//   fill_i           write {fill_addr_i, fill_data_i}
//   lookup_addr_i    address compared against the stored tag
//   hit_o, data_o    hit indication and stored target
module zcmt_entry_cache
   import zcmt_table_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter bit          EN     = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   inval_i,
   input  logic                   fill_i,
   input  logic [ADDR_W-1:0]      fill_addr_i,
   input  logic [ZCMT_DATA_W-1:0] fill_data_i,
   input  logic [ADDR_W-1:0]      lookup_addr_i,
   output logic                   hit_o,
   output logic [ZCMT_DATA_W-1:0] data_o
);

   logic                   valid_q;
   logic [ADDR_W-1:0]      tag_q;
   logic [ZCMT_DATA_W-1:0] data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else if (inval_i) begin
         valid_q <= 1'b0;
      end else if (fill_i) begin
         valid_q <= 1'b1;
         tag_q   <= fill_addr_i;
         data_q  <= fill_data_i;
      end
   end

   assign hit_o  = EN && valid_q && (tag_q == lookup_addr_i);
   assign data_o = data_q;

endmodule

// File: rtl/zcmt_table_fetch.sv
// Zcmt jump-table entry fetch: turns one table-entry address into a data-cache
// load (index phase, tag phase, kill, response-ID filter) and returns the
// 32-bit target as a single-cycle pulse. A 1-entry cache short-cuts repeats.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   flush_i                       abort current fetch
//   inval_i                       invalidate the entry cache
//   fetch_valid_i/fetch_ready_o   request handshake, fetch_addr_i address
//   rsp_valid_o/rsp_data_o/rsp_err_o  response pulse, target, misalign error
//   req_port_i/req_port_o         data-cache load port
module zcmt_table_fetch
   import zcmt_table_fetch_pkg::*;
#(
   parameter zcmt_cfg_t   CVA6Cfg        = ZCMT_CFG_DEFAULT,
   parameter type         dcache_req_i_t = zcmt_dcache_req_t,
   parameter type         dcache_req_o_t = zcmt_dcache_rsp_t,
   parameter int unsigned TRANS_ID       = 1,
   parameter bit          ENTRY_CACHE_EN = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic                    inval_i,
   input  logic                    fetch_valid_i,
   output logic                    fetch_ready_o,
   input  logic [CVA6Cfg.XLEN-1:0] fetch_addr_i,
   output logic                    rsp_valid_o,
   output logic [CVA6Cfg.XLEN-1:0] rsp_data_o,
   output logic                    rsp_err_o,
   input  dcache_req_o_t           req_port_i,
   output dcache_req_i_t           req_port_o
);

   localparam int unsigned XLEN    = CVA6Cfg.XLEN;
   localparam int unsigned IDX_W   = CVA6Cfg.DCACHE_INDEX_WIDTH;
   localparam int unsigned TAG_W   = CVA6Cfg.DCACHE_TAG_WIDTH;
   localparam int unsigned ALIGN_W = $clog2(ZCMT_ENTRY_BYTES);
   localparam bit          XLEN_OK = (XLEN == 32);
   localparam logic [ZCMT_ID_W-1:0] TID = ZCMT_ID_W'(TRANS_ID);

   zcmt_fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]       addr_q, addr_d;
   zcmt_fetch_rsp_t       rsp_q, rsp_d;
   logic                  hit;
   logic [ZCMT_DATA_W-1:0] cache_data;
   logic                  fill;
   logic                  rsp_match;
   logic                  bad_addr;

   assign rsp_match = req_port_i.data_rvalid && (req_port_i.data_rid == TID);
   assign bad_addr  = (fetch_addr_i[ALIGN_W-1:0] != '0) || !XLEN_OK;

   zcmt_entry_cache #(
      .ADDR_W (XLEN),
      .EN     (ENTRY_CACHE_EN)
   ) i_entry_cache (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .inval_i       (inval_i),
      .fill_i        (fill),
      .fill_addr_i   (addr_q),
      .fill_data_i   (req_port_i.data_rdata),
      .lookup_addr_i (fetch_addr_i),
      .hit_o         (hit),
      .data_o        (cache_data)
   );

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      rsp_d         = '0;
      rsp_d.data    = rsp_q.data;
      fill          = 1'b0;
      fetch_ready_o = 1'b0;
      req_port_o    = '0;

      // Port stays all-zero while idle; static load fields only once a fetch owns it.
      if (state_q != ZCMT_IDLE) begin
         req_port_o.data_be       = 4'hF;
         req_port_o.data_size     = 2'b10;
         req_port_o.data_id       = TID;
         req_port_o.address_index = ZCMT_IDX_W'(addr_q[IDX_W-1:0]);
         req_port_o.address_tag   = ZCMT_TAG_W'(addr_q[IDX_W+TAG_W-1:IDX_W]);
      end

      unique case (state_q)
         ZCMT_IDLE: begin
            fetch_ready_o = 1'b1;
            if (fetch_valid_i && !flush_i) begin
               addr_d = fetch_addr_i;
               if (bad_addr) begin
                  rsp_d.valid = 1'b1;
                  rsp_d.err   = 1'b1;
                  rsp_d.data  = '0;
               end else if (hit && !inval_i) begin
                  rsp_d.valid = 1'b1;
                  rsp_d.data  = cache_data;
               end else begin
                  state_d = ZCMT_REQ;
               end
            end
         end
         ZCMT_REQ: begin
            req_port_o.data_req = 1'b1;
            if (flush_i) begin
               state_d = req_port_i.data_gnt ? ZCMT_KILL : ZCMT_IDLE;
            end else if (req_port_i.data_gnt) begin
               state_d = ZCMT_TAG;
            end
         end
         ZCMT_TAG: begin
            req_port_o.tag_valid = 1'b1;
            if (flush_i) begin
               req_port_o.kill_req = 1'b1;
               state_d             = ZCMT_IDLE;
            end else begin
               state_d = ZCMT_WAIT;
            end
         end
         ZCMT_KILL: begin
            req_port_o.tag_valid = 1'b1;
            req_port_o.kill_req  = 1'b1;
            state_d              = ZCMT_IDLE;
         end
         ZCMT_WAIT: begin
            // A flush coinciding with the response consumes it, so no DROP needed.
            if (rsp_match) begin
               state_d = ZCMT_IDLE;
               if (!flush_i) begin
                  rsp_d.valid = 1'b1;
                  rsp_d.data  = req_port_i.data_rdata;
                  fill        = !inval_i;
               end
            end else if (flush_i) begin
               state_d = ZCMT_DROP;
            end
         end
         ZCMT_DROP: begin
            if (rsp_match) begin
               state_d = ZCMT_IDLE;
            end
         end
         default: state_d = ZCMT_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ZCMT_IDLE;
         addr_q  <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rsp_q   <= rsp_d;
      end
   end

   assign rsp_valid_o = rsp_q.valid;
   assign rsp_err_o   = rsp_q.err;
   assign rsp_data_o  = XLEN'(rsp_q.data);

endmodule

// File: tb/tb_zcmt_table_fetch.sv
module tb_zcmt_table_fetch;
   import zcmt_table_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush = 1'b0, inval = 1'b0, fvalid = 1'b0;
   logic [31:0] faddr = '0;
   logic        gnt = 1'b0, rvalid = 1'b0;
   logic [1:0]  rid = '0;
   logic [31:0] rdata = '0;
   logic        ready, rsp_valid, rsp_err;
   logic [31:0] rsp_data;
   zcmt_dcache_req_t req_o;
   zcmt_dcache_rsp_t req_i;

   assign req_i = '{data_gnt: gnt, data_rvalid: rvalid, data_rid: rid, data_rdata: rdata};

   always #5 clk = ~clk;

   zcmt_table_fetch #(
      .TRANS_ID       (1),
      .ENTRY_CACHE_EN (1'b1)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .flush_i       (flush),
      .inval_i       (inval),
      .fetch_valid_i (fvalid),
      .fetch_ready_o (ready),
      .fetch_addr_i  (faddr),
      .rsp_valid_o   (rsp_valid),
      .rsp_data_o    (rsp_data),
      .rsp_err_o     (rsp_err),
      .req_port_i    (req_i),
      .req_port_o    (req_o)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   int req_cycles = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Transaction-level reference: one miss in flight, tracked by which memory
   // milestones (grant, tag phase, response) have happened, plus the entry cache.
   bit          m_busy, m_granted, m_tagged, m_doomed, m_killcyc;
   logic [31:0] m_addr;
   bit          c_valid;
   logic [31:0] c_addr, c_data;
   bit          e_valid, e_err;
   logic [31:0] e_data;
   bit          m_match, m_fill;

   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         m_busy = 0; m_granted = 0; m_tagged = 0; m_doomed = 0; m_killcyc = 0;
         m_addr = '0; c_valid = 0; c_addr = '0; c_data = '0;
         e_valid = 0; e_err = 0; e_data = '0;
      end else begin
         e_valid = 0;
         e_err   = 0;
         m_fill  = 0;
         m_match = rvalid && (rid == 2'd1);
         if (m_killcyc) begin
            m_killcyc = 0;
         end else if (!m_busy) begin
            if (fvalid && !flush) begin
               if (faddr % 4 != 0) begin
                  e_valid = 1; e_err = 1; e_data = '0;
               end else if (c_valid && c_addr == faddr && !inval) begin
                  e_valid = 1; e_data = c_data;
               end else begin
                  m_busy = 1; m_addr = faddr;
                  m_granted = 0; m_tagged = 0; m_doomed = 0;
               end
            end
         end else if (!m_granted) begin
            if (flush) begin
               m_busy = 0; m_killcyc = gnt;
            end else if (gnt) begin
               m_granted = 1;
            end
         end else if (!m_tagged) begin
            if (flush) m_busy = 0;
            else m_tagged = 1;
         end else begin
            if (m_match) begin
               m_busy = 0;
               if (!flush && !m_doomed) begin
                  e_valid = 1; e_data = rdata; m_fill = !inval;
               end
            end else if (flush) begin
               m_doomed = 1;
            end
         end
         if (inval) c_valid = 0;
         else if (m_fill) begin
            c_valid = 1; c_addr = m_addr; c_data = rdata;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_ni && chk_en) begin
         check("cyc_ready", {31'b0, ready}, {31'b0, !(m_busy || m_killcyc)});
         check("cyc_rsp_valid", {31'b0, rsp_valid}, {31'b0, e_valid});
         check("cyc_rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
         if (e_valid) check("cyc_rsp_data", rsp_data, e_data);
         if (req_o.data_req) req_cycles++;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Drive a fetch from IDLE through grant and tag phase; returns in first WAIT cycle.
   task automatic miss_to_wait(input logic [31:0] a);
      fvalid = 1; faddr = a; gnt = 1;
      step();
      fvalid = 0;
      step();
      gnt = 0;
      step();
   endtask

   task automatic respond(input logic [31:0] d);
      rvalid = 1; rid = 2'd1; rdata = d;
      step();
      rvalid = 0;
   endtask

   int rc;

   initial begin
      #2;
      check("rst_ready", {31'b0, ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_req_zero", {31'b0, |req_o}, 32'd0);
      #10 rst_ni = 1;
      chk_en = 1;
      step();

      // Miss path
      fvalid = 1; faddr = 32'h0000_1008; gnt = 1;
      step();
      fvalid = 0;
      check("miss_req", {31'b0, req_o.data_req}, 32'd1);
      check("miss_idx", {20'b0, req_o.address_index}, 32'h008);
      check("miss_be", {28'b0, req_o.data_be}, 32'hF);
      check("miss_size", {30'b0, req_o.data_size}, 32'd2);
      check("miss_id", {30'b0, req_o.data_id}, 32'd1);
      check("miss_we", {31'b0, req_o.data_we}, 32'd0);
      step();
      gnt = 0;
      check("miss_tagv", {31'b0, req_o.tag_valid}, 32'd1);
      check("miss_tag", {12'b0, req_o.address_tag}, 32'h1);
      check("miss_req_off", {31'b0, req_o.data_req}, 32'd0);
      step();
      check("miss_wait_busy", {31'b0, ready}, 32'd0);
      step();
      respond(32'h0000_2400);
      check("miss_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("miss_rsp_data", rsp_data, 32'h0000_2400);
      check("miss_rsp_err", {31'b0, rsp_err}, 32'd0);
      step();
      check("miss_pulse_once", {31'b0, rsp_valid}, 32'd0);

      // Hit path, then invalidate forces memory again
      rc = req_cycles;
      fvalid = 1; faddr = 32'h0000_1008;
      step();
      fvalid = 0;
      check("hit_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("hit_rsp_data", rsp_data, 32'h0000_2400);
      step();
      check("hit_no_req", req_cycles, rc);
      inval = 1;
      step();
      inval = 0;
      miss_to_wait(32'h0000_1008);
      respond(32'h0000_2444);
      check("inval_refetch_data", rsp_data, 32'h0000_2444);

      // Misaligned
      rc = req_cycles;
      fvalid = 1; faddr = 32'h0000_100A;
      step();
      fvalid = 0;
      check("mis_valid", {31'b0, rsp_valid}, 32'd1);
      check("mis_err", {31'b0, rsp_err}, 32'd1);
      step();
      check("mis_no_req", req_cycles, rc);

      // Flush in WAIT -> drop the response, no fill
      miss_to_wait(32'h0000_3000);
      flush = 1;
      step();
      flush = 0;
      check("drop_busy", {31'b0, ready}, 32'd0);
      step();
      respond(32'hDEAD_BEEF);
      check("drop_no_rsp", {31'b0, rsp_valid}, 32'd0);
      check("drop_ready", {31'b0, ready}, 32'd1);
      fvalid = 1; faddr = 32'h0000_3000;
      step();
      fvalid = 0;
      check("drop_no_fill", {31'b0, req_o.data_req}, 32'd1);
      flush = 1;
      step();
      flush = 0;
      check("req_flush_drop", {31'b0, req_o.data_req}, 32'd0);

      // Flush in TAG -> kill, stray response ignored, then normal fetch
      fvalid = 1; faddr = 32'h0000_2000; gnt = 1;
      step();
      fvalid = 0;
      step();
      gnt = 0; flush = 1;
      #1;
      check("tag_kill", {31'b0, req_o.kill_req}, 32'd1);
      check("tag_kill_tagv", {31'b0, req_o.tag_valid}, 32'd1);
      step();
      flush = 0;
      check("tag_kill_idle", {31'b0, ready}, 32'd1);
      respond(32'h5555_5555);
      check("stray_ignored", {31'b0, rsp_valid}, 32'd0);
      miss_to_wait(32'h0000_2000);
      respond(32'h0000_3000);
      check("after_kill_valid", {31'b0, rsp_valid}, 32'd1);
      check("after_kill_data", rsp_data, 32'h0000_3000);

      // Flush together with grant -> KILL cycle
      fvalid = 1; faddr = 32'h0000_4000;
      step();
      fvalid = 0; gnt = 1; flush = 1;
      step();
      gnt = 0; flush = 0;
      check("kill_state_kill", {31'b0, req_o.kill_req}, 32'd1);
      check("kill_state_busy", {31'b0, ready}, 32'd0);
      step();
      check("kill_done", {31'b0, req_o.kill_req}, 32'd0);

      // Grant stall + foreign rid
      fvalid = 1; faddr = 32'h0000_1010;
      step();
      fvalid = 0;
      for (int i = 0; i < 5; i++) begin
         check("stall_req", {31'b0, req_o.data_req}, 32'd1);
         check("stall_idx", {20'b0, req_o.address_index}, 32'h010);
         step();
      end
      gnt = 1;
      step();
      gnt = 0;
      step();
      rvalid = 1; rid = 2'd0; rdata = 32'hBAD0_BAD0;
      step();
      check("foreign_rid", {31'b0, rsp_valid}, 32'd0);
      respond(32'h0000_0100);
      check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_rsp_data", rsp_data, 32'h0000_0100);

      // Flush and matching rvalid in the same WAIT cycle
      miss_to_wait(32'h0000_1030);
      flush = 1;
      respond(32'h0000_7777);
      flush = 0;
      check("flush_rvalid_none", {31'b0, rsp_valid}, 32'd0);
      check("flush_rvalid_idle", {31'b0, ready}, 32'd1);

      // inval during fill suppresses the fill
      miss_to_wait(32'h0000_1040);
      inval = 1;
      respond(32'h0000_1111);
      inval = 0;
      check("inval_fill_rsp", rsp_data, 32'h0000_1111);
      fvalid = 1; faddr = 32'h0000_1040;
      step();
      fvalid = 0;
      check("inval_fill_miss", {31'b0, req_o.data_req}, 32'd1);
      flush = 1;
      step();
      flush = 0;

      // Async reset mid-WAIT clears outputs and the entry cache
      miss_to_wait(32'h0000_1060);
      respond(32'h0000_6060);
      miss_to_wait(32'h0000_1050);
      #1 rst_ni = 0;
      #1;
      check("arst_ready", {31'b0, ready}, 32'd1);
      check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("arst_rsp_data", rsp_data, 32'd0);
      check("arst_rsp_err", {31'b0, rsp_err}, 32'd0);
      check("arst_req_zero", {31'b0, |req_o}, 32'd0);
      #2 rst_ni = 1;
      step();
      fvalid = 1; faddr = 32'h0000_1060;
      step();
      fvalid = 0;
      check("arst_cache_cleared", {31'b0, req_o.data_req}, 32'd1);
      flush = 1;
      step();
      flush = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
